// File: rtl/debounce_edge_conditioner.sv
// Multi-channel input conditioner: 2-FF synchronizer, symmetric sample-tick debouncer and edge pulses.
// Optional auto-repeat on held inputs is compiled in with DEBOUNCE_AUTO_REPEAT_EN.
module debounce_edge_conditioner #(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200,
  parameter int EDGE_MODE      = 0,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] signal_in,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] rising_pulse,
  output logic [WIDTH-1:0] falling_pulse,
  output logic [WIDTH-1:0] edge_pulse,
  output logic [WIDTH-1:0] repeat_pulse
);

  localparam int SW = $clog2(SAMPLE_CNT_MAX);
  localparam int CW = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
  localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CNT_MAX);

  if (SAMPLE_CNT_MAX < 2 || PULSE_CNT_MAX < 1 || REPEAT_RATE < 1 ||
      REPEAT_RATE > REPEAT_DELAY) begin : g_bad_params
    $error("debounce_edge_conditioner: invalid parameter set");
  end

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] deb_q, deb_d, deb_dly_q;
  logic [SW-1:0]    smp_cnt_q, smp_cnt_d;
  logic             sample;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  assign sample    = (smp_cnt_q == SAMPLE_LAST);
  assign smp_cnt_d = sample ? '0 : smp_cnt_q + SW'(1);

  // A matching input clears the run; a full run of mismatching ticks flips the level.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == PULSE_LAST) begin
        deb_d[i] = ~deb_q[i];
        cnt_d[i] = '0;
      end else if (sample) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      smp_cnt_q <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= signal_in;
      s2_q      <= s1_q;
      smp_cnt_q <= smp_cnt_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign debounced_signal = deb_q;
  assign rising_pulse     = deb_q & ~deb_dly_q;
  assign falling_pulse    = ~deb_q & deb_dly_q;

  if (EDGE_MODE == 1) begin : g_edge_fall
    assign edge_pulse = falling_pulse;
  end else if (EDGE_MODE == 2) begin : g_edge_both
    assign edge_pulse = rising_pulse | falling_pulse;
  end else begin : g_edge_rise
    assign edge_pulse = rising_pulse;
  end

`ifdef DEBOUNCE_AUTO_REPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_RATE);

  logic [HW-1:0]    hold_q [WIDTH];
  logic [HW-1:0]    hold_d [WIDTH];
  logic [WIDTH-1:0] rep_hit;

  // Hold counter is zero on the rising cycle, so a repeat can never coincide with it.
  always_comb begin
    rep_hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hold_d[i]  = hold_q[i];
      rep_hit[i] = deb_q[i] && (hold_q[i] == HOLD_LAST);
      if (!deb_q[i]) begin
        hold_d[i] = '0;
      end else if (rep_hit[i]) begin
        hold_d[i] = HOLD_RELOAD;
      end else if (sample) begin
        hold_d[i] = hold_q[i] + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) hold_q[i] <= hold_d[i];
    end
  end

  assign repeat_pulse = rep_hit;
`else
  assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_debounce_edge_conditioner.sv
// Bench for debounce_edge_conditioner: three instances (EDGE_MODE 0/1/2) share one stimulus.
// Build with +define+DEBOUNCE_AUTO_REPEAT_EN to exercise the auto-repeat path.
module tb_debounce_edge_conditioner;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sig = '0;
  logic [W-1:0] deb_m  [3];
  logic [W-1:0] rise_m [3];
  logic [W-1:0] fall_m [3];
  logic [W-1:0] edge_m [3];
  logic [W-1:0] rep_m  [3];

  int total = 0;
  int bad   = 0;
  int rise_c [2];
  int fall_c [2];
  int edge_c [3][2];
  int rep_c  [2];
  int rep_total = 0;

  typedef struct {
    logic [1:0] sig;
    int         ncyc;
    logic [1:0] deb;
    int         r0, f0, r1, f1;
  } step_t;

  step_t tbl [9];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    debounce_edge_conditioner #(
      .WIDTH(W), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3), .EDGE_MODE(m),
      .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .signal_in(sig),
      .debounced_signal(deb_m[m]),
      .rising_pulse(rise_m[m]),
      .falling_pulse(fall_m[m]),
      .edge_pulse(edge_m[m]),
      .repeat_pulse(rep_m[m])
    );
  end

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rise_m[0][c] === 1'b1) rise_c[c]++;
      if (fall_m[0][c] === 1'b1) fall_c[c]++;
      if (rep_m[0][c] === 1'b1) rep_c[c]++;
      for (int m = 0; m < 3; m++) if (edge_m[m][c] === 1'b1) edge_c[m][c]++;
    end
    for (int m = 0; m < 3; m++) if (rep_m[m] !== 2'b00) rep_total++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    for (int c = 0; c < 2; c++) begin
      rise_c[c] = 0;
      fall_c[c] = 0;
      rep_c[c]  = 0;
      for (int m = 0; m < 3; m++) edge_c[m][c] = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int er, ef, ee;

    tbl[0] = '{2'b01, 20, 2'b01, 1, 0, 0, 0};
    tbl[1] = '{2'b11, 20, 2'b11, 0, 0, 1, 0};
    tbl[2] = '{2'b10, 20, 2'b10, 0, 1, 0, 0};
    tbl[3] = '{2'b01, 20, 2'b01, 1, 0, 0, 1};
    tbl[4] = '{2'b00, 20, 2'b00, 0, 1, 0, 0};
    tbl[5] = '{2'b01,  4, 2'b00, 0, 0, 0, 0};
    tbl[6] = '{2'b00, 20, 2'b00, 0, 0, 0, 0};
    tbl[7] = '{2'b10,  8, 2'b00, 0, 0, 0, 0};
    tbl[8] = '{2'b00, 20, 2'b00, 0, 0, 0, 0};
    clr_counts();

    // Reset held with inputs high: every output of every instance stays low.
    rst_n = 1'b0;
    sig   = 2'b11;
    for (int k = 0; k < 3; k++) begin
      cyc();
      for (int m = 0; m < 3; m++)
        chk($sformatf("reset_m%0d_k%0d", m, k),
            {22'd0, deb_m[m], rise_m[m], fall_m[m], edge_m[m], rep_m[m]}, 32'd0);
    end
    rst_n = 1'b1;
    cyc();
    for (int m = 0; m < 3; m++)
      chk($sformatf("post_reset_m%0d", m),
          {22'd0, deb_m[m], rise_m[m], fall_m[m], edge_m[m], rep_m[m]}, 32'd0);
    rst_n = 1'b0;
    sig   = 2'b00;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Table of settled steps: final level and pulse counts over each step.
    for (int i = 0; i < 9; i++) begin
      sig = tbl[i].sig;
      clr_counts();
      repeat (tbl[i].ncyc) cyc();
      for (int m = 0; m < 3; m++)
        chk($sformatf("step%0d_deb_m%0d", i, m), {30'd0, deb_m[m]}, {30'd0, tbl[i].deb});
      for (int c = 0; c < 2; c++) begin
        er = (c == 0) ? tbl[i].r0 : tbl[i].r1;
        ef = (c == 0) ? tbl[i].f0 : tbl[i].f1;
        chk($sformatf("step%0d_rise_ch%0d", i, c), rise_c[c], er);
        chk($sformatf("step%0d_fall_ch%0d", i, c), fall_c[c], ef);
        for (int m = 0; m < 3; m++) begin
          ee = (m == 0) ? er : (m == 1) ? ef : er + ef;
          chk($sformatf("step%0d_edge_m%0d_ch%0d", i, m, c), edge_c[m][c], ee);
        end
`ifndef DEBOUNCE_AUTO_REPEAT_EN
        chk($sformatf("step%0d_rep_ch%0d", i, c), rep_c[c], 0);
`endif
      end
    end

    // Rise latency and single-cycle pulse on ch0.
    sig = 2'b01;
    n = 0;
    do begin cyc(); n++; end while (deb_m[0][0] !== 1'b1 && n < 40);
    chk_range("rise_latency", n, 11, 15);
    chk("rise_pulse_on", {30'd0, rise_m[0]}, 32'd1);
    chk("edge_m0_on", {30'd0, edge_m[0]}, 32'd1);
    chk("edge_m1_quiet", {30'd0, edge_m[1]}, 32'd0);
    chk("edge_m2_on", {30'd0, edge_m[2]}, 32'd1);
    cyc();
    chk("rise_pulse_off", {30'd0, rise_m[0]}, 32'd0);
    chk("edge_m2_off", {30'd0, edge_m[2]}, 32'd0);

    // One-cycle low glitches every 6 cycles are filtered.
    repeat (6) cyc();
    clr_counts();
    for (int g = 0; g < 5; g++) begin
      sig = 2'b00;
      cyc();
      sig = 2'b01;
      repeat (5) cyc();
    end
    chk("glitch_deb_held", {31'd0, deb_m[0][0]}, 32'd1);
    chk("glitch_no_fall", fall_c[0], 0);
    sig = 2'b00;
    n = 0;
    do begin cyc(); n++; end while (deb_m[0][0] !== 1'b0 && n < 40);
    chk_range("fall_latency", n, 11, 15);
    chk("fall_pulse_on", {30'd0, fall_m[0]}, 32'd1);
    chk("edge_m0_fall_quiet", {30'd0, edge_m[0]}, 32'd0);
    chk("edge_m1_fall_on", {30'd0, edge_m[1]}, 32'd1);
    chk("edge_m2_fall_on", {30'd0, edge_m[2]}, 32'd1);
    cyc();
    chk("fall_pulse_off", {30'd0, fall_m[0]}, 32'd0);

    // Both channels rise together.
    repeat (6) cyc();
    sig = 2'b11;
    n = 0;
    do begin cyc(); n++; end while (rise_m[0] === 2'b00 && n < 40);
    chk_range("dual_latency", n, 11, 15);
    chk("dual_rise_same_cycle", {30'd0, rise_m[0]}, 32'd3);
    sig = 2'b00;
    repeat (20) cyc();

    // Reset while ch1 is debounced high: no falling pulse, fresh rise afterwards.
    sig = 2'b10;
    repeat (20) cyc();
    chk("pre_reset_deb1", {31'd0, deb_m[0][1]}, 32'd1);
    clr_counts();
    rst_n = 1'b0;
    cyc();
    chk("midreset_deb", {30'd0, deb_m[0]}, 32'd0);
    chk("midreset_fall", {30'd0, fall_m[0]}, 32'd0);
    rst_n = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (rise_m[0][1] !== 1'b1 && n < 40);
    chk("rerise_latency", n, 13);
    chk("midreset_no_fall_count", fall_c[1], 0);
    sig = 2'b00;
    repeat (20) cyc();

`ifdef DEBOUNCE_AUTO_REPEAT_EN
    // Held ch0: first repeat after 4 ticks, then every 2 ticks; none after release.
    sig = 2'b01;
    n = 0;
    do begin cyc(); n++; end while (rise_m[0][0] !== 1'b1 && n < 40);
    chk_range("rep_rise_latency", n, 11, 15);
    chk("no_rep_on_rise", {31'd0, rep_m[0][0]}, 32'd0);
    n = 0;
    do begin cyc(); n++; end while (rep_m[0][0] !== 1'b1 && n < 40);
    chk_range("rep_first_delay", n, 13, 17);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin cyc(); n++; end while (rep_m[0][0] !== 1'b1 && n < 20);
      chk($sformatf("rep_period_%0d", k), n, 8);
    end
    sig = 2'b00;
    n = 0;
    do begin cyc(); n++; end while (deb_m[0][0] !== 1'b0 && n < 40);
    chk_range("rep_release_latency", n, 11, 15);
    clr_counts();
    repeat (30) cyc();
    chk("rep_after_release", rep_c[0], 0);
`else
    // Compiled out: a long hold never produces a repeat.
    clr_counts();
    sig = 2'b01;
    repeat (60) cyc();
    chk("hold_deb", {30'd0, deb_m[0]}, 32'd1);
    chk("hold_no_repeat", rep_c[0], 0);
    sig = 2'b00;
    repeat (20) cyc();
    chk("rep_total_zero", rep_total, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
